// File: rtl/dmac_pkg.sv
// dmac_pkg: shared FSM states, register-select codes, MODE bit positions and transfer types
package dmac_pkg;
   typedef enum logic [2:0] {S_IDLE, S_REQ, S_RD, S_WR, S_XF, S_NEXT} state_t;
   localparam logic [1:0] SEL_SRC = 2'b00;
   localparam logic [1:0] SEL_CNT = 2'b01;
   localparam logic [1:0] SEL_DST = 2'b10;
   localparam logic [1:0] SEL_MODE = 2'b11;
   localparam int M_EN = 0;
   localparam int M_BURST = 3;
   localparam int M_AUTO = 4;
   localparam int M_FIX = 5;
   localparam int MW = 6;
   localparam logic [1:0] T_MM = 2'b00;
   localparam logic [1:0] T_IOM = 2'b01;
   localparam logic [1:0] T_MIO = 2'b10;
   localparam logic [1:0] T_RSV = 2'b11;
endpackage

// File: rtl/dmac_arbiter.sv
// dmac_arbiter: one-hot grant from an eligible vector, fixed (lowest index) or round-robin priority
module dmac_arbiter #(
   parameter int NCH = 4,
   parameter int ROTATE = 0
) (
   input  logic           i_clk,
   input  logic           i_rst_n,
   input  logic           i_take,
   input  logic [NCH-1:0] i_elig,
   output logic [NCH-1:0] o_grant
);
   localparam int PW = NCH > 1 ? $clog2(NCH) : 1;
   logic [PW-1:0] r_ptr;
   logic [PW-1:0] w_idx;
   // r_ptr is the first slot searched; it moves to one past the channel just served
   function automatic int slot(input int p, input int k);
      return (ROTATE != 0) ? (p + k) % NCH : k;
   endfunction
   always_comb begin
      o_grant = '0;
      w_idx = '0;
      for (int k = NCH - 1; k >= 0; k--)
         if (i_elig[slot(int'(r_ptr), k)]) begin
            o_grant = '0;
            o_grant[slot(int'(r_ptr), k)] = 1'b1;
            w_idx = PW'(slot(int'(r_ptr), k));
         end
   end
   always_ff @(posedge i_clk or negedge i_rst_n)
      if (!i_rst_n) r_ptr <= '0;
      else if (i_take && |i_elig) r_ptr <= PW'((int'(w_idx) + 1) % NCH);
endmodule

// File: rtl/dmac_multi.sv
// dmac_multi: NCH-channel DMA controller sharing one bus through HLD/HLDA,
// with mem-mem, IO-mem and mem-IO transfers, burst, autoinit and fill addressing.
module dmac_multi import dmac_pkg::*; #(
   parameter int NCH = 4,
   parameter int AW = 16,
   parameter int DW = 8,
   parameter int CW = 16,
   parameter int ROTATE = 0
) (
   input  logic                                  CLK,
   input  logic                                  RST_N,
   input  logic                                  REGW,
   input  logic [(NCH > 1 ? $clog2(NCH) : 1)-1:0] REGCH,
   input  logic [1:0]                            REGSEL,
   input  logic [AW-1:0]                         Setup,
   input  logic [NCH-1:0]                        DREQ,
   input  logic                                  HLDA,
   input  logic                                  RDY,
   input  logic [DW-1:0]                         Data_in,
   output logic                                  HLD,
   output logic [NCH-1:0]                        DACK,
   output logic                                  MEMR,
   output logic                                  MEMW,
   output logic                                  IOR,
   output logic                                  IOW,
   output logic [AW-1:0]                         Addrbus,
   output logic [DW-1:0]                         Data_out,
   output logic [NCH-1:0]                        EOP
);
   localparam int CHW = NCH > 1 ? $clog2(NCH) : 1;
   logic [AW-1:0] r_src [NCH];
   logic [AW-1:0] r_dst [NCH];
   logic [AW-1:0] r_bsrc [NCH];
   logic [AW-1:0] r_bdst [NCH];
   logic [CW-1:0] r_cnt [NCH];
   logic [CW-1:0] r_bcnt [NCH];
   logic [MW-1:0] r_mode [NCH];
   state_t        r_state;
   logic [CHW-1:0] r_own;
   logic [DW-1:0] r_tmp;
   logic [NCH-1:0] w_elig;
   logic [NCH-1:0] w_grant;
   logic [CHW-1:0] w_gidx;
   logic [1:0]    w_otype;
   logic [CW-1:0] w_ocnt;
   logic [AW-1:0] w_osrc;
   logic [AW-1:0] w_odst;
   logic          w_wr_ok;
   logic          w_act;
   always_comb begin
      w_gidx = '0;
      for (int i = 0; i < NCH; i++) begin
         w_elig[i] = r_mode[i][M_EN] && r_cnt[i] != '0 && r_mode[i][2:1] != T_RSV && DREQ[i];
         if (w_grant[i]) w_gidx = CHW'(i);
      end
   end
   dmac_arbiter #(.NCH(NCH), .ROTATE(ROTATE)) u_arb (
      .i_clk(CLK), .i_rst_n(RST_N), .i_take(r_state == S_IDLE), .i_elig(w_elig), .o_grant(w_grant)
   );
   assign w_otype = r_mode[r_own][2:1];
   assign w_ocnt = r_cnt[r_own];
   assign w_osrc = r_src[r_own];
   assign w_odst = r_dst[r_own];
   // the bus owner's registers are frozen against CPU writes until it returns to IDLE
   assign w_wr_ok = REGW && int'(REGCH) < NCH && (r_state == S_IDLE || REGCH != r_own);
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_state <= S_IDLE;
         r_own <= '0;
         r_tmp <= '0;
         for (int i = 0; i < NCH; i++) begin
            r_src[i] <= '0;
            r_dst[i] <= '0;
            r_bsrc[i] <= '0;
            r_bdst[i] <= '0;
            r_cnt[i] <= '0;
            r_bcnt[i] <= '0;
            r_mode[i] <= '0;
         end
      end else begin
         if (w_wr_ok)
            case (REGSEL)
               SEL_SRC: begin r_src[REGCH] <= Setup; r_bsrc[REGCH] <= Setup; end
               SEL_CNT: begin r_cnt[REGCH] <= Setup[CW-1:0]; r_bcnt[REGCH] <= Setup[CW-1:0]; end
               SEL_DST: begin r_dst[REGCH] <= Setup; r_bdst[REGCH] <= Setup; end
               default: r_mode[REGCH] <= Setup[MW-1:0];
            endcase
         case (r_state)
            S_IDLE: if (|w_elig) begin r_own <= w_gidx; r_state <= S_REQ; end
            S_REQ: if (HLDA) r_state <= (w_otype == T_MM) ? S_RD : S_XF;
            S_RD: if (RDY) begin r_tmp <= Data_in; r_state <= S_WR; end
            S_WR, S_XF: if (RDY) begin
               if (!r_mode[r_own][M_FIX]) r_src[r_own] <= w_osrc + 1'b1;
               r_dst[r_own] <= w_odst + 1'b1;
               r_cnt[r_own] <= w_ocnt - 1'b1;
               r_state <= S_NEXT;
            end
            S_NEXT: if (w_ocnt == '0) begin
               if (r_mode[r_own][M_AUTO]) begin
                  r_src[r_own] <= r_bsrc[r_own];
                  r_dst[r_own] <= r_bdst[r_own];
                  r_cnt[r_own] <= r_bcnt[r_own];
               end else r_mode[r_own][M_EN] <= 1'b0;
               r_state <= S_IDLE;
            end else if (r_mode[r_own][M_BURST] && HLDA && (w_otype == T_MM || DREQ[r_own]))
               r_state <= (w_otype == T_MM) ? S_RD : S_XF;
            else r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
      end
   end
   assign w_act = r_state == S_RD || r_state == S_WR || r_state == S_XF;
   assign HLD = r_state != S_IDLE;
   assign DACK = w_act ? NCH'(1) << r_own : '0;
   assign MEMR = r_state == S_RD || (r_state == S_XF && w_otype == T_MIO);
   assign MEMW = r_state == S_WR || (r_state == S_XF && w_otype == T_IOM);
   assign IOR = r_state == S_XF && w_otype == T_IOM;
   assign IOW = r_state == S_XF && w_otype == T_MIO;
   assign Addrbus = r_state == S_RD ? w_osrc :
                    r_state == S_WR ? w_odst :
                    r_state == S_XF ? (w_otype == T_IOM ? w_odst : w_osrc) : '0;
   assign EOP = (r_state == S_NEXT && w_ocnt == '0) ? NCH'(1) << r_own : '0;
   assign Data_out = r_tmp;
endmodule

// File: tb/tb_dmac_multi.sv
// tb_dmac_multi: directed checks of dmac_multi; a second ROTATE=1 instance shares all inputs
module tb_dmac_multi;
   logic CLK = 0, RST_N = 1, REGW = 0, HLDA = 0, RDY = 1;
   logic [1:0] REGCH = 0, REGSEL = 0;
   logic [15:0] Setup = 0;
   logic [3:0] DREQ = 0;
   logic [7:0] Data_in;
   logic HLD, MEMR, MEMW, IOR, IOW;
   logic [3:0] DACK, EOP;
   logic [15:0] Addrbus;
   logic [7:0] Data_out;
   logic HLD_1, MEMR_1, MEMW_1, IOR_1, IOW_1;
   logic [3:0] DACK_1, EOP_1;
   logic [15:0] Addrbus_1;
   logic [7:0] Data_out_1;
   logic [3:0] s0 [4];
   logic [3:0] s1 [4];
   int n0, n1;
   int n_run = 0, n_fail = 0;
   always #5 CLK = ~CLK;
   // memory model: read data is a fixed function of the address
   assign Data_in = Addrbus[7:0] ^ 8'h5A;
   dmac_multi #(.ROTATE(0)) u0 (
      .CLK(CLK), .RST_N(RST_N), .REGW(REGW), .REGCH(REGCH), .REGSEL(REGSEL), .Setup(Setup),
      .DREQ(DREQ), .HLDA(HLDA), .RDY(RDY), .Data_in(Data_in), .HLD(HLD), .DACK(DACK),
      .MEMR(MEMR), .MEMW(MEMW), .IOR(IOR), .IOW(IOW), .Addrbus(Addrbus), .Data_out(Data_out), .EOP(EOP)
   );
   dmac_multi #(.ROTATE(1)) u1 (
      .CLK(CLK), .RST_N(RST_N), .REGW(REGW), .REGCH(REGCH), .REGSEL(REGSEL), .Setup(Setup),
      .DREQ(DREQ), .HLDA(HLDA), .RDY(RDY), .Data_in(Data_in), .HLD(HLD_1), .DACK(DACK_1),
      .MEMR(MEMR_1), .MEMW(MEMW_1), .IOR(IOR_1), .IOW(IOW_1), .Addrbus(Addrbus_1),
      .Data_out(Data_out_1), .EOP(EOP_1)
   );
   function automatic logic [4:0] strb();
      return {HLD, MEMR, MEMW, IOR, IOW};
   endfunction
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_run++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask
   task automatic step();
      @(negedge CLK);
   endtask
   task automatic regw(input int ch, input int sel, input logic [15:0] d);
      REGW = 1;
      REGCH = ch[1:0];
      REGSEL = sel[1:0];
      Setup = d;
      step();
      REGW = 0;
   endtask
   initial begin
      #100000;
      $display("FAIL watchdog: simulation still running, expected finish");
      $fatal(1);
   end
   initial begin
      #1 RST_N = 0;
      #1;
      chk("rst_strb", 32'(strb()), 0);
      chk("rst_addr", 32'(Addrbus), 0);
      chk("rst_dack_eop", {24'h0, DACK, EOP}, 0);
      chk("rst_dout", 32'(Data_out), 0);
      step(); step();
      RST_N = 1;
      step();
      // mem-mem burst on ch0
      regw(0, 0, 16'h00A4); regw(0, 1, 16'd3); regw(0, 2, 16'h0050); regw(0, 3, 16'h0009);
      HLDA = 1; RDY = 1; DREQ = 4'b0001;
      step(); chk("t1_req", 32'(strb()), 32'b10000);
      for (int b = 0; b < 3; b++) begin
         step();
         chk("t1_rd_strb", 32'(strb()), 32'b11000);
         chk("t1_rd_addr", 32'(Addrbus), 32'h00A4 + b);
         chk("t1_rd_dack", 32'(DACK), 1);
         step();
         chk("t1_wr_strb", 32'(strb()), 32'b10100);
         chk("t1_wr_addr", 32'(Addrbus), 32'h0050 + b);
         chk("t1_wr_data", 32'(Data_out), 32'((8'hA4 + b) ^ 8'h5A));
         step();
         chk("t1_next_eop", 32'(EOP), (b == 2) ? 1 : 0);
      end
      step(); chk("t1_idle", 32'(strb()), 0);
      step(); chk("t1_en_clear", 32'(HLD), 0);
      DREQ = 0;
      // single-mode IO->mem on ch1
      regw(1, 2, 16'h2000); regw(1, 1, 16'd2); regw(1, 3, 16'h0003);
      DREQ = 4'b0010;
      for (int b = 0; b < 2; b++) begin
         step(); chk("t2_req", 32'(strb()), 32'b10000);
         step();
         chk("t2_xf_strb", 32'(strb()), 32'b10110);
         chk("t2_xf_addr", 32'(Addrbus), 32'h2000 + b);
         chk("t2_xf_dack", 32'(DACK), 32'b0010);
         step(); chk("t2_next_eop", 32'(EOP), (b == 1) ? 32'b0010 : 0);
         step(); chk("t2_idle_hld", 32'(HLD), 0);
      end
      DREQ = 0;
      // priority: fixed (u0) versus round-robin (u1)
      RST_N = 0; step(); RST_N = 1;
      regw(0, 0, 16'h0100); regw(0, 1, 16'd2); regw(0, 3, 16'h0005);
      regw(2, 0, 16'h0200); regw(2, 1, 16'd2); regw(2, 3, 16'h0005);
      for (int i = 0; i < 4; i++) begin s0[i] = 0; s1[i] = 0; end
      n0 = 0; n1 = 0;
      DREQ = 4'b0101;
      for (int i = 0; i < 24; i++) begin
         step();
         if (DACK != 0 && n0 < 4) begin s0[n0] = DACK; n0++; end
         if (DACK_1 != 0 && n1 < 4) begin s1[n1] = DACK_1; n1++; end
      end
      chk("t3_fix_0", 32'(s0[0]), 32'b0001);
      chk("t3_fix_1", 32'(s0[1]), 32'b0001);
      chk("t3_fix_2", 32'(s0[2]), 32'b0100);
      chk("t3_fix_3", 32'(s0[3]), 32'b0100);
      chk("t3_rr_0", 32'(s1[0]), 32'b0001);
      chk("t3_rr_1", 32'(s1[1]), 32'b0100);
      chk("t3_rr_2", 32'(s1[2]), 32'b0001);
      chk("t3_rr_3", 32'(s1[3]), 32'b0100);
      DREQ = 0;
      // HLDA withheld, then RDY wait in RD
      regw(0, 0, 16'h0030); regw(0, 2, 16'h0040); regw(0, 1, 16'd1); regw(0, 3, 16'h0001);
      HLDA = 0; DREQ = 4'b0001;
      for (int i = 0; i < 3; i++) begin step(); chk("t4_hlda_wait", 32'(strb()), 32'b10000); end
      HLDA = 1; RDY = 0;
      for (int i = 0; i < 4; i++) begin
         step();
         chk("t4_rdy_strb", 32'(strb()), 32'b11000);
         chk("t4_rdy_addr", 32'(Addrbus), 32'h0030);
      end
      RDY = 1;
      step();
      chk("t4_wr_addr", 32'(Addrbus), 32'h0040);
      chk("t4_wr_data", 32'(Data_out), 32'h6A);
      step(); chk("t4_eop", 32'(EOP), 32'b0001);
      step(); chk("t4_idle", 32'(strb()), 0);
      DREQ = 0;
      // autoinit + fixed source on ch3
      regw(3, 0, 16'h0010); regw(3, 2, 16'h0080); regw(3, 1, 16'd2); regw(3, 3, 16'h0039);
      DREQ = 4'b1000;
      step(); chk("t5_req", 32'(strb()), 32'b10000);
      for (int b = 0; b < 2; b++) begin
         step(); chk("t5_rd_addr", 32'(Addrbus), 32'h0010);
         step();
         chk("t5_wr_addr", 32'(Addrbus), 32'h0080 + b);
         chk("t5_wr_data", 32'(Data_out), 32'h4A);
         step(); chk("t5_eop", 32'(EOP), (b == 1) ? 32'b1000 : 0);
      end
      step(); chk("t5_idle", 32'(strb()), 0);
      step(); chk("t5_rereq", 32'(strb()), 32'b10000);
      step(); chk("t5_reload_src", 32'(Addrbus), 32'h0010);
      step(); chk("t5_reload_dst", 32'(Addrbus), 32'h0080);
      DREQ = 0;
      repeat (6) step();
      chk("t5_done", 32'(strb()), 0);
      // owner register protection during a ch0 burst
      regw(0, 0, 16'h0000); regw(0, 2, 16'h0100); regw(0, 1, 16'd4); regw(0, 3, 16'h0009);
      DREQ = 4'b0001;
      step(); chk("t6_req", 32'(strb()), 32'b10000);
      step(); chk("t6_rd0", 32'(Addrbus), 32'h0000);
      regw(0, 1, 16'd1); chk("t6_wr0", 32'(Addrbus), 32'h0100);
      regw(1, 2, 16'h3000); chk("t6_prot", 32'(EOP), 0);
      regw(1, 1, 16'd1); chk("t6_rd1", 32'(Addrbus), 32'h0001);
      regw(1, 3, 16'h0003); chk("t6_wr1", 32'(Addrbus), 32'h0101);
      for (int b = 2; b < 4; b++) begin
         step(); chk("t6_next", 32'(EOP), 0);
         step(); chk("t6_rd", 32'(Addrbus), b);
         step(); chk("t6_wr", 32'(Addrbus), 32'h0100 + b);
      end
      step(); chk("t6_eop", 32'(EOP), 32'b0001);
      DREQ = 4'b0010;
      step(); chk("t6_idle", 32'(HLD), 0);
      step(); chk("t6_ch1_req", 32'(strb()), 32'b10000);
      step();
      chk("t6_ch1_strb", 32'(strb()), 32'b10110);
      chk("t6_ch1_addr", 32'(Addrbus), 32'h3000);
      chk("t6_ch1_dack", 32'(DACK), 32'b0010);
      step(); chk("t6_ch1_eop", 32'(EOP), 32'b0010);
      DREQ = 0;
      step();
      // asynchronous reset during WR
      regw(0, 0, 16'h0005); regw(0, 2, 16'h0006); regw(0, 1, 16'd1); regw(0, 3, 16'h0001);
      DREQ = 4'b0001;
      step(); step(); step();
      chk("t7_wr_strb", 32'(strb()), 32'b10100);
      chk("t7_wr_data", 32'(Data_out), 32'h5F);
      #2 RST_N = 0;
      #1;
      chk("t7_rst_strb", 32'(strb()), 0);
      chk("t7_rst_addr", 32'(Addrbus), 0);
      chk("t7_rst_data", 32'(Data_out), 0);
      chk("t7_rst_dack", {24'h0, DACK, EOP}, 0);
      step();
      RST_N = 1; DREQ = 4'b1111;
      step(); step();
      chk("t7_regs_clear", 32'(strb()), 0);
      DREQ = 0;
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end
endmodule
